// File: rtl/rbot_timer_pkg.sv
// Shared timing definitions for the robot timer blocks.
// Holds the default prescale constant and the stopwatch state type.
package rbot_timer_pkg;

   // Clock cycles per millisecond at the nominal 250 MHz system clock.
   localparam int CLKS_PER_MS_DEFAULT = 250000;

   // Stopwatch measurement states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } sw_state_t;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: emits a one-cycle tick on the wrap cycle.
// clear has priority over enable and forces the count back to zero.
module ms_tick_gen
   import rbot_timer_pkg::*;
#(
   parameter int CLKS_PER_MS = CLKS_PER_MS_DEFAULT
)
(
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int PW = $clog2(CLKS_PER_MS);
   localparam logic [PW-1:0] LAST = PW'(CLKS_PER_MS - 1);

   logic [PW-1:0] r_presc;
   logic          w_at_last;

   assign w_at_last = (r_presc == LAST);
   assign tick      = enable && !clear && w_at_last;

   // Count enabled cycles, wrapping after CLKS_PER_MS of them.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_presc <= '0;
      end else if (clear) begin
         r_presc <= '0;
      end else if (enable) begin
         if (w_at_last) begin
            r_presc <= '0;
         end else begin
            r_presc <= r_presc + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ms_stopwatch.sv
// Millisecond stopwatch: counts whole ms between start and stop pulses.
// Define MS_STOPWATCH_SATURATE_EN to saturate elapsed and flag overflow.
module ms_stopwatch
   import rbot_timer_pkg::*;
#(
   parameter int CLKS_PER_MS = CLKS_PER_MS_DEFAULT,
   parameter int WIDTH       = 16
)
(
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   output logic [WIDTH-1:0] elapsed,
   output logic             running,
   output logic             done,
   output logic             overflow
);

   sw_state_t        r_state;
   logic [WIDTH-1:0] r_elapsed;
   logic             r_running;
   logic             r_done;
   logic             w_tick;
   logic             w_enable;

   // Prescaler only advances on plain RUN cycles; the stop edge is frozen.
   assign w_enable = (r_state == RUN) && !start && !stop;

   ms_tick_gen #(
      .CLKS_PER_MS (CLKS_PER_MS)
   ) u_tick (
      .clock  (clock),
      .reset  (reset),
      .clear  (start),
      .enable (w_enable),
      .tick   (w_tick)
   );

`ifdef MS_STOPWATCH_SATURATE_EN
   localparam logic [WIDTH-1:0] ELAPSED_MAX = '1;

   logic r_overflow;

   // Sticky overflow: set when a tick arrives at full scale.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_overflow <= 1'b0;
      end else if (start) begin
         r_overflow <= 1'b0;
      end else if (w_tick && (r_elapsed == ELAPSED_MAX)) begin
         r_overflow <= 1'b1;
      end
   end

   assign overflow = r_overflow;
`else
   assign overflow = 1'b0;
`endif

   // Measurement FSM with registered elapsed/running/done outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_elapsed <= '0;
         r_running <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (start) begin
            r_state   <= RUN;
            r_elapsed <= '0;
            r_running <= 1'b1;
         end else begin
            unique case (r_state)
               RUN: begin
                  if (stop) begin
                     r_state   <= HOLD;
                     r_running <= 1'b0;
                     r_done    <= 1'b1;
                  end else if (w_tick) begin
`ifdef MS_STOPWATCH_SATURATE_EN
                     if (r_elapsed != ELAPSED_MAX) begin
                        r_elapsed <= r_elapsed + 1'b1;
                     end
`else
                     r_elapsed <= r_elapsed + 1'b1;
`endif
                  end
               end
               IDLE, HOLD: begin
                  r_state <= r_state;
               end
               default: begin
                  r_state <= IDLE;
               end
            endcase
         end
      end
   end

   assign elapsed = r_elapsed;
   assign running = r_running;
   assign done    = r_done;

endmodule

// File: doc/ms_stopwatch.md
# ms_stopwatch

Millisecond stopwatch: measures the elapsed whole milliseconds between a `start` pulse and a `stop` pulse and holds the result until the next measurement. It is the measuring counterpart of the fixed-delay timer. The timer turns a duration into a `done` event; this block turns a pair of events into a duration. It times robot motion and solve sequences and reports the result to the display and control logic.

## Interface
- `CLKS_PER_MS`, default 250000: clock cycles per millisecond. Must be ≥ 2.
- `WIDTH`, default 16: width of the millisecond count.
- `clock`  in  1  sole clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle pulse; begins or restarts a measurement.
- `stop`  in  1  single-cycle pulse; ends the measurement.
- `elapsed`  out  WIDTH  millisecond count; live while running, frozen after stop.
- `running`  out  1  high while a measurement is in progress.
- `done`  out  1  one-cycle pulse on the edge where `stop` is accepted.
- `overflow`  out  1  sticky; count exceeded 2^WIDTH−1 during this measurement.

## Operation
- States:
  - IDLE: after reset.
  - RUN: measuring.
  - HOLD: result frozen.
- On `reset`: state IDLE; `elapsed`=0, `running`=0, `done`=0, `overflow`=0; prescaler=0.
- `start` is sampled high in any state:
  - Go to RUN; prescaler←0, `elapsed`←0, `overflow`←0, `running`←1.
  - `start` while in RUN restarts the measurement and produces no `done`.
- Each edge in RUN without `start` or `stop`:
  - If prescaler == CLKS_PER_MS−1: prescaler←0 and `elapsed`←`elapsed`+1.
  - Otherwise: prescaler←prescaler+1.
- `stop` sampled in RUN without `start`:
  - Go to HOLD; `running`←0; `done`←1 for exactly one cycle.
  - `elapsed` and prescaler are not updated on that edge.
- `stop` in IDLE or HOLD is ignored; no `done`.
- `start` and `stop` on the same edge: `start` wins in every state.
- HOLD keeps `elapsed` and `overflow` until the next `start` or `reset`.
- Prescaler width is $clog2(CLKS_PER_MS). Increments of `elapsed` are modulo 2^WIDTH unless saturation is compiled in (see Configuration).

## Timing
- Let `start` be accepted at edge t0 and `stop` at edge s, with s > t0.
- Final `elapsed` = floor((s − t0 − 1) / CLKS_PER_MS).
- `elapsed` changes on the same edge as the prescaler wrap; it is a registered output with no added latency.
- `done` is high in the cycle following edge s. The frozen `elapsed` is valid in that same cycle.
- `running` rises one edge after t0 is sampled, i.e. it is registered at t0. It falls registered at s.
- Reset asserted mid-measurement clears everything at once, asynchronously. Operation resumes on the first edge after deassertion.

## Configuration
- `MS_STOPWATCH_SATURATE_EN` defined:
  - When `elapsed` == 2^WIDTH−1 and a prescaler wrap occurs, `elapsed` holds at 2^WIDTH−1 and `overflow`←1.
  - `overflow` stays high until the next `start` or `reset`.
- Not defined:
  - `elapsed` wraps to 0.
  - `overflow` is tied to 0.

## Structure
- Shared package `rbot_timer_pkg`:
  - Constant `CLKS_PER_MS_DEFAULT` = 250000.
  - Enumerated state type (IDLE, RUN, HOLD).
- Sub-module `ms_tick_gen`:
  - Contains the prescaler.
  - Inputs: `clear` and `enable`.
  - Output: a `tick` pulse on the wrap cycle.
  - The stopwatch FSM and `elapsed` counter consume `tick`.

## Test plan
All scenarios use CLKS_PER_MS=4 and WIDTH=4.
- Basic measurement: `start` at t0, `stop` at t0+9 → `elapsed`=2, `done` high for one cycle, `running` 0 afterward.
- Wrap boundary: `stop` at t0+8 → `elapsed`=1; `stop` at t0+5 → `elapsed`=1; `stop` at t0+4 → `elapsed`=0.
- Restart: `start`, then a second `start` at t0+10, then `stop` 5 edges after the second → `elapsed`=1, exactly one `done`, `overflow`=0.
- Same-edge and ignored pulses: `start` and `stop` together during RUN → restart, no `done`. `stop` in IDLE → no `done`, `elapsed` stays 0. `stop` in HOLD → value unchanged.
- Overflow: run 70 edges, then `stop`.
  - With the macro: `elapsed`=15, `overflow`=1.
  - Without the macro: `elapsed`=(69/4) mod 16=1, `overflow`=0.
- Asynchronous reset mid-RUN at t0+6: all outputs go to 0 immediately, without waiting for a clock edge. A subsequent `stop` produces no `done`.
